// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID/EXE pipeline register with bubble insertion and freeze; optional perf counters under ID_EXE_PERF_CNT_EN
module id_exe_stage_reg #(
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            flush,
  input  logic            hazard_detected,
  input  logic [WORD-1:0] PC_in,
  input  logic            WB_EN_in,
  input  logic            MEM_R_EN_in,
  input  logic            MEM_W_EN_in,
  input  logic            B_in,
  input  logic            S_in,
  input  logic [3:0]      EXE_CMD_in,
  input  logic [WORD-1:0] Val_Rn_in,
  input  logic [WORD-1:0] Val_Rm_in,
  input  logic            imm_in,
  input  logic [11:0]     Shift_operand_in,
  input  logic [23:0]     Signed_imm_24_in,
  input  logic [3:0]      Dest_in,
  input  logic [3:0]      src1_in,
  input  logic [3:0]      src2_in,
  input  logic [3:0]      SR_in,
  output logic [WORD-1:0] PC_out,
  output logic            WB_EN_out,
  output logic            MEM_R_EN_out,
  output logic            MEM_W_EN_out,
  output logic            B_out,
  output logic            S_out,
  output logic [3:0]      EXE_CMD_out,
  output logic [WORD-1:0] Val_Rn_out,
  output logic [WORD-1:0] Val_Rm_out,
  output logic            imm_out,
  output logic [11:0]     Shift_operand_out,
  output logic [23:0]     Signed_imm_24_out,
  output logic [3:0]      Dest_out,
  output logic [3:0]      src1_out,
  output logic [3:0]      src2_out,
  output logic [3:0]      SR_out,
  output logic            valid_out,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     flush_cnt
);
  logic bubble;
  assign bubble = flush | hazard_detected;
  always_ff @(posedge clk) begin
    if (rst || (!freeze && bubble))
      {PC_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, EXE_CMD_out, Val_Rn_out,
       Val_Rm_out, imm_out, Shift_operand_out, Signed_imm_24_out, Dest_out, src1_out, src2_out,
       SR_out, valid_out} <= '0;
    else if (!freeze)
      {PC_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, EXE_CMD_out, Val_Rn_out,
       Val_Rm_out, imm_out, Shift_operand_out, Signed_imm_24_out, Dest_out, src1_out, src2_out,
       SR_out, valid_out} <= {PC_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, EXE_CMD_in,
       Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in, Signed_imm_24_in, Dest_in, src1_in, src2_in,
       SR_in, 1'b1};
  end
`ifdef ID_EXE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!freeze) begin
      if (hazard_detected && !flush && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_id_exe_stage_reg.sv
// tb_id_exe_stage_reg: randomized self-checking bench for id_exe_stage_reg against a field-level reference model
module tb_id_exe_stage_reg;
  typedef struct packed {
    logic [31:0] pc;
    logic        wb, mr, mw, b, s;
    logic [3:0]  cmd;
    logic [31:0] rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] si;
    logic [3:0]  dest, s1, s2, sr;
  } fields_t;
  logic clk = 1'b0, rst = 1'b0, freeze = 1'b0, flush = 1'b0, hz = 1'b0;
  fields_t in_f, exp_f, obs_f;
  logic exp_v;
  int exp_stall_n, exp_flush_n;
  int total = 0, bad = 0;
  logic [31:0] PC_out, Val_Rn_out, Val_Rm_out;
  logic WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, imm_out, valid_out;
  logic [3:0] EXE_CMD_out, Dest_out, src1_out, src2_out, SR_out;
  logic [11:0] Shift_operand_out;
  logic [23:0] Signed_imm_24_out;
  logic [15:0] stall_cnt, flush_cnt;
  always #5 clk = ~clk;
  id_exe_stage_reg #(.WORD(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard_detected(hz),
    .PC_in(in_f.pc), .WB_EN_in(in_f.wb), .MEM_R_EN_in(in_f.mr), .MEM_W_EN_in(in_f.mw),
    .B_in(in_f.b), .S_in(in_f.s), .EXE_CMD_in(in_f.cmd), .Val_Rn_in(in_f.rn), .Val_Rm_in(in_f.rm),
    .imm_in(in_f.imm), .Shift_operand_in(in_f.sh), .Signed_imm_24_in(in_f.si), .Dest_in(in_f.dest),
    .src1_in(in_f.s1), .src2_in(in_f.s2), .SR_in(in_f.sr),
    .PC_out(PC_out), .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out),
    .B_out(B_out), .S_out(S_out), .EXE_CMD_out(EXE_CMD_out), .Val_Rn_out(Val_Rn_out),
    .Val_Rm_out(Val_Rm_out), .imm_out(imm_out), .Shift_operand_out(Shift_operand_out),
    .Signed_imm_24_out(Signed_imm_24_out), .Dest_out(Dest_out), .src1_out(src1_out),
    .src2_out(src2_out), .SR_out(SR_out), .valid_out(valid_out),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  assign obs_f = {PC_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, EXE_CMD_out,
                  Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out, Signed_imm_24_out,
                  Dest_out, src1_out, src2_out, SR_out};
  function automatic logic [15:0] sat_cnt(input int n);
`ifdef ID_EXE_PERF_CNT_EN
    return (n > 65535) ? 16'hFFFF : n[15:0];
`else
    return (n >= 0) ? 16'h0000 : 16'h0000;
`endif
  endfunction
  task automatic chk(input string tag, input logic [157:0] obs, input logic [157:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic randomize_inputs();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    in_f = r[157:0];
  endtask
  task automatic cycle(input string tag, input bit do_chk);
    @(posedge clk);
    if (rst) begin
      exp_f = '0;
      exp_v = 1'b0;
      exp_stall_n = 0;
      exp_flush_n = 0;
    end else if (!freeze) begin
      if (flush || hz) begin
        exp_f = '0;
        exp_v = 1'b0;
        if (flush) exp_flush_n++;
        else exp_stall_n++;
      end else begin
        exp_f = in_f;
        exp_v = 1'b1;
      end
    end
    @(negedge clk);
    if (do_chk) begin
      chk({tag, ".fields"}, 158'(obs_f), 158'(exp_f));
      chk({tag, ".valid"}, 158'(valid_out), 158'(exp_v));
      chk({tag, ".stall_cnt"}, 158'(stall_cnt), 158'(sat_cnt(exp_stall_n)));
      chk({tag, ".flush_cnt"}, 158'(flush_cnt), 158'(sat_cnt(exp_flush_n)));
    end
  endtask
  initial begin
    exp_f = '0;
    exp_v = 1'b0;
    exp_stall_n = 0;
    exp_flush_n = 0;
    randomize_inputs();
    @(negedge clk);
    rst = 1'b1;
    cycle("reset0", 1'b1);
    randomize_inputs();
    cycle("reset1", 1'b1);
    rst = 1'b0;
    randomize_inputs();
    in_f.wb = 1'b1;
    in_f.dest = 4'h5;
    in_f.rn = 32'hDEADBEEF;
    cycle("load", 1'b1);
    chk("load.WB_EN", 158'(WB_EN_out), 158'(1'b1));
    chk("load.Dest", 158'(Dest_out), 158'(4'h5));
    chk("load.Val_Rn", 158'(Val_Rn_out), 158'(32'hDEADBEEF));
    chk("load.valid", 158'(valid_out), 158'(1'b1));
    hz = 1'b1;
    in_f.wb = 1'b1;
    in_f.mw = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle("hazard", 1'b1);
      chk("hazard.valid", 158'(valid_out), 158'(1'b0));
      chk("hazard.WB_EN", 158'(WB_EN_out), 158'(1'b0));
      chk("hazard.MEM_W_EN", 158'(MEM_W_EN_out), 158'(1'b0));
      chk("hazard.Dest", 158'(Dest_out), 158'(4'h0));
    end
    hz = 1'b0;
    cycle("hazard_release", 1'b1);
    chk("hazard_release.valid", 158'(valid_out), 158'(1'b1));
    chk("hazard_release.MEM_W_EN", 158'(MEM_W_EN_out), 158'(1'b1));
    flush = 1'b1;
    hz = 1'b1;
    cycle("flush_hz", 1'b1);
    chk("flush_hz.valid", 158'(valid_out), 158'(1'b0));
    flush = 1'b0;
    hz = 1'b0;
    randomize_inputs();
    cycle("after_flush", 1'b1);
    for (int i = 0; i < 200; i++) begin
      randomize_inputs();
      rst = ($urandom_range(0, 49) == 0);
      freeze = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      hz = ($urandom_range(0, 4) == 0);
      cycle("random", 1'b1);
    end
    rst = 1'b0;
    freeze = 1'b0;
    flush = 1'b0;
    hz = 1'b0;
    randomize_inputs();
    in_f.cmd = 4'h2;
    cycle("freeze_load", 1'b1);
    freeze = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      hz = i[0];
      cycle("freeze", 1'b1);
      chk("freeze.EXE_CMD", 158'(EXE_CMD_out), 158'(4'h2));
      chk("freeze.valid", 158'(valid_out), 158'(1'b1));
    end
    flush = 1'b0;
    hz = 1'b0;
    freeze = 1'b0;
    randomize_inputs();
    cycle("resume", 1'b1);
    freeze = 1'b1;
    rst = 1'b1;
    cycle("rst_freeze", 1'b1);
    chk("rst_freeze.fields", 158'(obs_f), 158'(0));
    chk("rst_freeze.valid", 158'(valid_out), 158'(1'b0));
    rst = 1'b0;
    freeze = 1'b0;
`ifdef ID_EXE_PERF_CNT_EN
    hz = 1'b1;
    for (int i = 0; i < 65539; i++) cycle("saturate", 1'b0);
    cycle("saturate", 1'b1);
    chk("saturate.stall_cnt", 158'(stall_cnt), 158'(16'hFFFF));
    hz = 1'b0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
